// File: rtl/adaptive_green_timer.sv
// Counts vehicle arrivals per approach over one signal cycle and, on entry to
// West orange, turns the counts into next-cycle green times for the light FSM.
module adaptive_green_timer #(
  parameter int DEF_G       = 20,
  parameter int MIN_G       = 10,
  parameter int MAX_G       = 50,
  parameter int SEC_PER_CAR = 2,
  parameter int T_OR        = 6
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       adaptive_en,
  input  logic       car_n,
  input  logic       car_e,
  input  logic       car_s,
  input  logic       car_w,
  input  logic [4:0] state,
  output logic [7:0] TGn,
  output logic [7:0] TGe,
  output logic [7:0] TGs,
  output logic [7:0] TGw,
  output logic [7:0] TO,
  output logic       upd,
  output logic       busy
);

  localparam logic [4:0] W_ORANGE = 5'd8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CALC   = 2'd1,
    COMMIT = 2'd2
  } ctrl_t;

  ctrl_t       r_ctrl;
  ctrl_t       w_ctrl_next;
  logic [1:0]  r_idx;
  logic [4:0]  r_state_d;
  logic [3:0]  r_car_d;
  logic [3:0]  w_car;
  logic [3:0]  w_rise;
  logic        w_or_entry;
  logic        w_snap_en;
  logic        w_calc_en;
  logic        w_commit_en;
  logic [11:0] w_raw;
  logic [7:0]  w_res;

  // Index order is N, E, S, W throughout.
  logic [7:0]  r_cnt    [4];
  logic [7:0]  r_snap   [4];
  logic [7:0]  r_shadow [4];
  logic [7:0]  r_tg     [4];

  assign w_car      = {car_w, car_s, car_e, car_n};
  assign w_rise     = w_car & ~r_car_d;
  assign w_or_entry = (state == W_ORANGE) && (r_state_d != W_ORANGE);

  // 12-bit intermediate so a saturated count times SEC_PER_CAR cannot wrap.
  assign w_raw = 12'(MIN_G) + 12'(r_snap[r_idx]) * 12'(SEC_PER_CAR);
  assign w_res = (w_raw > 12'(MAX_G)) ? 8'(MAX_G) : w_raw[7:0];

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_ctrl <= IDLE;
    end else begin
      r_ctrl <= w_ctrl_next;
    end
  end

  always_comb begin
    w_ctrl_next = r_ctrl;
    w_snap_en   = 1'b0;
    w_calc_en   = 1'b0;
    w_commit_en = 1'b0;
    upd         = 1'b0;
    busy        = 1'b0;
    case (r_ctrl)
      IDLE: begin
        if (w_or_entry) begin
          w_snap_en   = 1'b1;
          w_ctrl_next = CALC;
        end
      end
      CALC: begin
        busy      = 1'b1;
        w_calc_en = 1'b1;
        if (r_idx == 2'd3) begin
          w_ctrl_next = COMMIT;
        end
      end
      COMMIT: begin
        upd         = 1'b1;
        w_commit_en = 1'b1;
        w_ctrl_next = IDLE;
      end
      default: w_ctrl_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_idx     <= 2'd0;
      r_state_d <= 5'd0;
      r_car_d   <= 4'd0;
    end else begin
      r_state_d <= state;
      r_car_d   <= w_car;
      if (w_snap_en) begin
        r_idx <= 2'd0;
      end else if (w_calc_en) begin
        r_idx <= r_idx + 2'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < 4; i++) begin
        r_cnt[i]    <= 8'd0;
        r_snap[i]   <= 8'd0;
        r_shadow[i] <= 8'd0;
        r_tg[i]     <= 8'(DEF_G);
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        // An edge landing on the snapshot cycle belongs to the new window.
        if (w_snap_en) begin
          r_snap[i] <= r_cnt[i];
          r_cnt[i]  <= {7'd0, w_rise[i]};
        end else if (w_rise[i] && (r_cnt[i] != 8'hFF)) begin
          r_cnt[i] <= r_cnt[i] + 8'd1;
        end
        if (w_calc_en && (r_idx == 2'(i))) begin
          r_shadow[i] <= w_res;
        end
        if (w_commit_en) begin
          r_tg[i] <= adaptive_en ? r_shadow[i] : 8'(DEF_G);
        end
      end
    end
  end

  assign TGn = r_tg[0];
  assign TGe = r_tg[1];
  assign TGs = r_tg[2];
  assign TGw = r_tg[3];
  assign TO  = 8'(T_OR);

endmodule

// File: tb/tb_adaptive_green_timer.sv
// Randomised and directed bench for adaptive_green_timer, checked against a
// window/count reference model that schedules commits by cycle count.
module tb_adaptive_green_timer;

  localparam int DEF_G = 20;
  localparam int MIN_G = 10;
  localparam int MAX_G = 50;
  localparam int SPC   = 2;
  localparam int T_OR  = 6;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       adaptive_en = 1'b1;
  logic       car_n = 1'b0, car_e = 1'b0, car_s = 1'b0, car_w = 1'b0;
  logic [4:0] state = 5'd0;
  logic [7:0] TGn, TGe, TGs, TGw, TO;
  logic       upd, busy;

  always #5 clk = ~clk;

  adaptive_green_timer dut (
    .clk(clk), .reset(reset), .adaptive_en(adaptive_en),
    .car_n(car_n), .car_e(car_e), .car_s(car_s), .car_w(car_w),
    .state(state),
    .TGn(TGn), .TGe(TGe), .TGs(TGs), .TGw(TGw), .TO(TO),
    .upd(upd), .busy(busy)
  );

  int errors = 0;
  int checks = 0;
  int cnt [4];
  int snap [4];
  int exp_tg [4];
  int r = -1;
  bit [3:0] prev_car = 4'd0;
  int prev_st = 0;
  int upd_count = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  function automatic int green_for(input int s);
    int raw;
    raw = MIN_G + s * SPC;
    return (raw > MAX_G) ? MAX_G : raw;
  endfunction

  // One clock of stimulus; the model tracks windows and the commit schedule.
  task automatic step(input bit rst_n, input bit [3:0] cars, input int st, input bit aen);
    bit idle;
    bit committed;
    committed = 1'b0;
    reset = rst_n;
    {car_w, car_s, car_e, car_n} = cars;
    state = 5'(st);
    adaptive_en = aen;
    if (!rst_n) begin
      for (int d = 0; d < 4; d++) begin
        cnt[d] = 0;
        exp_tg[d] = DEF_G;
      end
      prev_car = 4'd0;
      prev_st = 0;
      r = -1;
    end else begin
      idle = (r < 0);
      if (r == 0) begin
        for (int d = 0; d < 4; d++) exp_tg[d] = aen ? green_for(snap[d]) : DEF_G;
        r = -1;
        committed = 1'b1;
      end
      if (idle && st == 8 && prev_st != 8) begin
        for (int d = 0; d < 4; d++) begin
          snap[d] = cnt[d];
          cnt[d] = 0;
        end
        r = 5;
      end
      for (int d = 0; d < 4; d++) begin
        if (cars[d] && !prev_car[d] && cnt[d] < 255) cnt[d]++;
      end
      prev_car = cars;
      prev_st = st;
    end
    @(posedge clk);
    #1;
    if (r > 0) r--;
    check("upd", upd, (r == 0));
    check("busy", busy, (r >= 1 && r <= 4));
    check("TGn", TGn, exp_tg[0]);
    check("TGe", TGe, exp_tg[1]);
    check("TGs", TGs, exp_tg[2]);
    check("TGw", TGw, exp_tg[3]);
    check("TO", TO, T_OR);
    if (upd === 1'b1) upd_count++;
    if (committed)
      $display("commit aen=%0d TGn=%0d TGe=%0d TGs=%0d TGw=%0d", aen, TGn, TGe, TGs, TGw);
  endtask

  task automatic pulses(input int n, input int e, input int s, input int w, input bit aen);
    int m;
    m = n;
    if (e > m) m = e;
    if (s > m) m = s;
    if (w > m) m = w;
    for (int i = 0; i < m; i++) begin
      step(1'b1, {(i < w), (i < s), (i < e), (i < n)}, 0, aen);
      step(1'b1, 4'd0, 0, aen);
    end
  endtask

  task automatic trigger(input bit aen);
    step(1'b1, 4'd0, 7, aen);
    for (int i = 0; i < 8; i++) step(1'b1, 4'd0, 8, aen);
  endtask

  int base;
  int st_r;
  bit aen_r;

  initial begin
    for (int i = 0; i < 3; i++) step(1'b0, 4'd0, 0, 1'b1);
    check("rst_TGn", TGn, 20);
    check("rst_TO", TO, 6);

    pulses(3, 0, 25, 5, 1'b1);
    trigger(1'b1);
    check("dir_TGn", TGn, 16);
    check("dir_TGe", TGe, 10);
    check("dir_TGs", TGs, 50);
    check("dir_TGw", TGw, 20);

    for (int i = 0; i < 40; i++) step(1'b1, 4'b0010, 0, 1'b1);
    step(1'b1, 4'd0, 7, 1'b1);
    step(1'b1, 4'b0010, 8, 1'b1);
    for (int i = 0; i < 7; i++) step(1'b1, 4'd0, 8, 1'b1);
    check("held_TGe", TGe, 12);
    step(1'b1, 4'd0, 0, 1'b1);
    trigger(1'b1);
    check("newwin_TGe", TGe, 12);
    check("newwin_TGn", TGn, 10);

    pulses(0, 0, 0, 300, 1'b1);
    trigger(1'b1);
    check("sat_TGw", TGw, 50);

    base = upd_count;
    pulses(10, 10, 10, 10, 1'b0);
    trigger(1'b0);
    check("fixed_TGs", TGs, 20);
    check("fixed_upd", upd_count - base, 1);
    pulses(10, 10, 10, 10, 1'b1);
    trigger(1'b1);
    check("adapt_TGn", TGn, 30);

    base = upd_count;
    pulses(3, 3, 3, 3, 1'b1);
    step(1'b1, 4'd0, 7, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b1, 4'd0, 8, 1'b1);
    step(1'b0, 4'd0, 8, 1'b1);
    for (int i = 0; i < 8; i++) step(1'b1, 4'd0, 0, 1'b1);
    check("abort_TGn", TGn, 20);
    check("abort_upd", upd_count - base, 0);

    base = upd_count;
    pulses(2, 2, 2, 2, 1'b1);
    step(1'b1, 4'd0, 7, 1'b1);
    step(1'b1, 4'd0, 8, 1'b1);
    step(1'b1, 4'd0, 0, 1'b1);
    for (int i = 0; i < 8; i++) step(1'b1, 4'd0, 8, 1'b1);
    check("busy_reentry_upd", upd_count - base, 1);
    check("busy_reentry_TGn", TGn, 14);

    st_r = 0;
    aen_r = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 9) == 0) st_r = $urandom_range(0, 11);
      if ($urandom_range(0, 19) == 0) aen_r = ~aen_r;
      step(($urandom_range(0, 599) != 0), 4'($urandom_range(0, 15) & $urandom_range(0, 15)),
           st_r, aen_r);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
